scumvcontroller_tx_arbiter: RTL and testbench

Packet-atomic round-robin arbiter that shares the controller's single UART transmit byte stream among three response sources: ASC scan-chain responses, STL TileLink responses and a status/telemetry source. It sits between the subsystem response FIFOs and the UART transmitter's valid/ready byte input. Once a source is granted, it keeps the grant until its full fixed-length packet has been sent, so bytes from different packets never interleave. A stall watchdog reclaims the link if a granted source stops supplying bytes mid-packet.

---
 rtl/scumvcontroller_tx_arbiter.sv | 167 ++++++++++++++++
 tb/tb_scumvcontroller_tx_arbiter.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scumvcontroller_tx_arbiter.sv
// Packet-atomic round-robin arbiter sharing the UART TX byte stream
// between ASC, STL and status response sources, with a stall watchdog.
module scumvcontroller_tx_arbiter #(
  parameter int ASC_RESP_LEN   = 1,
  parameter int STL_RESP_LEN   = 16,
  parameter int STAT_LEN       = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       asc_valid,
  input  logic [7:0] asc_data,
  output logic       asc_ready,
  input  logic       stl_valid,
  input  logic [7:0] stl_data,
  output logic       stl_ready,
  input  logic       stat_valid,
  input  logic [7:0] stat_data,
  output logic       stat_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [1:0] grant,
  output logic       busy,
  output logic       timeout_pulse,
  output logic [7:0] err_count
);

  localparam logic [7:0]  ASC_LAST  = 8'(ASC_RESP_LEN - 1);
  localparam logic [7:0]  STL_LAST  = 8'(STL_RESP_LEN - 1);
  localparam logic [7:0]  STAT_LAST = 8'(STAT_LEN - 1);
  localparam logic [23:0] WD_LIMIT  = 24'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t      state, state_nxt;
  logic [1:0]  last, last_nxt, grant_nxt;
  logic [7:0]  byte_cnt, byte_cnt_nxt;
  logic [23:0] wd_cnt, wd_cnt_nxt;
  logic [7:0]  err_nxt;
  logic        pulse_nxt;

  logic [3:0]  req;
  logic [1:0]  pick;
  logic [1:0]  cand;
  logic        sel_valid;
  logic [7:0]  sel_data;
  logic [7:0]  pkt_last;
  logic        hs;

  assign req  = {stat_valid, stl_valid, asc_valid, 1'b0};
  assign busy = (state == XFER);

  always_comb begin
    sel_valid = 1'b0;
    sel_data  = 8'h00;
    pkt_last  = 8'h00;
    unique case (grant)
      2'd1: begin
        sel_valid = asc_valid;
        sel_data  = asc_data;
        pkt_last  = ASC_LAST;
      end
      2'd2: begin
        sel_valid = stl_valid;
        sel_data  = stl_data;
        pkt_last  = STL_LAST;
      end
      2'd3: begin
        sel_valid = stat_valid;
        sel_data  = stat_data;
        pkt_last  = STAT_LAST;
      end
      default: ;
    endcase
  end

  // Search upward from the source after last, wrapping stat -> asc.
  always_comb begin
    pick = 2'd0;
    cand = 2'd0;
    for (int i = 1; i <= 3; i++) begin
      cand = 2'(((int'(last) + i - 1) % 3) + 1);
      if (pick == 2'd0 && req[cand])
        pick = cand;
    end
  end

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant;
    last_nxt     = last;
    byte_cnt_nxt = byte_cnt;
    wd_cnt_nxt   = wd_cnt;
    err_nxt      = err_count;
    pulse_nxt    = 1'b0;
    asc_ready    = 1'b0;
    stl_ready    = 1'b0;
    stat_ready   = 1'b0;
    tx_valid     = 1'b0;
    tx_data      = 8'h00;
    hs           = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick != 2'd0) begin
          grant_nxt    = pick;
          byte_cnt_nxt = 8'h00;
          wd_cnt_nxt   = 24'h0;
          state_nxt    = XFER;
        end
      end
      XFER: begin
        tx_data    = sel_data;
        tx_valid   = sel_valid;
        asc_ready  = (grant == 2'd1) && tx_ready;
        stl_ready  = (grant == 2'd2) && tx_ready;
        stat_ready = (grant == 2'd3) && tx_ready;
        hs         = sel_valid && tx_ready;
        if (hs) begin
          wd_cnt_nxt   = 24'h0;
          byte_cnt_nxt = byte_cnt + 8'd1;
          if (byte_cnt == pkt_last) begin
            last_nxt     = grant;
            grant_nxt    = 2'd0;
            byte_cnt_nxt = 8'h00;
            state_nxt    = IDLE;
          end
        end else if (!sel_valid) begin
          wd_cnt_nxt = wd_cnt + 24'd1;
          // Stalled mid-packet: abort and hand the link to the others.
          if (wd_cnt == WD_LIMIT) begin
            pulse_nxt    = 1'b1;
            err_nxt      = (err_count == 8'hFF) ? err_count
                                                : err_count + 8'd1;
            last_nxt     = grant;
            grant_nxt    = 2'd0;
            byte_cnt_nxt = 8'h00;
            wd_cnt_nxt   = 24'h0;
            state_nxt    = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      grant         <= 2'd0;
      last          <= 2'd3;
      byte_cnt      <= 8'h00;
      wd_cnt        <= 24'h0;
      err_count     <= 8'h00;
      timeout_pulse <= 1'b0;
    end else begin
      state         <= state_nxt;
      grant         <= grant_nxt;
      last          <= last_nxt;
      byte_cnt      <= byte_cnt_nxt;
      wd_cnt        <= wd_cnt_nxt;
      err_count     <= err_nxt;
      timeout_pulse <= pulse_nxt;
    end
  end

endmodule

// File: tb/tb_scumvcontroller_tx_arbiter.sv
// Self-checking bench for scumvcontroller_tx_arbiter: directed scenarios
// plus randomized traffic against a packet-level scoreboard.
module tb_scumvcontroller_tx_arbiter;

  localparam int ASC_L  = 1;
  localparam int STL_L  = 16;
  localparam int STAT_L = 4;
  localparam int TO     = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       asc_valid = 0, stl_valid = 0, stat_valid = 0;
  logic [7:0] asc_data = 0, stl_data = 0, stat_data = 0;
  logic       asc_ready, stl_ready, stat_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 0;
  logic [1:0] grant;
  logic       busy, timeout_pulse;
  logic [7:0] err_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  scumvcontroller_tx_arbiter #(
    .ASC_RESP_LEN(ASC_L), .STL_RESP_LEN(STL_L),
    .STAT_LEN(STAT_L), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(rst),
    .asc_valid(asc_valid), .asc_data(asc_data), .asc_ready(asc_ready),
    .stl_valid(stl_valid), .stl_data(stl_data), .stl_ready(stl_ready),
    .stat_valid(stat_valid), .stat_data(stat_data),
    .stat_ready(stat_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .grant(grant), .busy(busy), .timeout_pulse(timeout_pulse),
    .err_count(err_count)
  );

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    {asc_valid, stl_valid, stat_valid} = 3'b000;
    {asc_data, stl_data, stat_data} = 24'h0;
    tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  function automatic int plen(int s);
    return (s == 1) ? ASC_L : (s == 2) ? STL_L : (s == 3) ? STAT_L : 0;
  endfunction

  function automatic int rr(int lst, logic [2:0] r);
    int s = lst;
    repeat (3) begin
      s = (s == 3) ? 1 : s + 1;
      if (r[s-1]) return s;
    end
    return 0;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    {asc_valid, stl_valid, stat_valid} = 3'b111;
    tx_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({grant, busy, tx_valid, asc_ready, stl_ready, stat_ready,
           err_count, tx_data, timeout_pulse} !== 23'd0) begin
        failures++;
        $display("FAIL reset_state grant=%0d busy=%b txv=%b rdy=%b%b%b err=%0d",
                 grant, busy, tx_valid, asc_ready, stl_ready, stat_ready,
                 err_count);
      end
    end
    to_pos();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (grant !== 2'd0) begin
      failures++;
      $display("FAIL reset_idle grant=%0d want 0", grant);
    end
    to_pos();
    @(negedge clk);
    checks++;
    if ({grant, busy} !== {2'd1, 1'b1}) begin
      failures++;
      $display("FAIL reset_first_grant grant=%0d busy=%b want 1/1",
               grant, busy);
    end
    {asc_valid, stl_valid, stat_valid} = 3'b000;
  endtask

  task automatic test_single_stl();
    do_reset();
    stl_valid = 1'b1;
    tx_ready  = 1'b1;
    for (int i = 0; i < 16; i++) begin
      to_pos();
      stl_data = 8'(i);
      @(negedge clk);
      checks++;
      if ({grant, tx_valid, stl_ready, asc_ready, stat_ready, tx_data}
          !== {2'd2, 4'b1100, 8'(i)}) begin
        failures++;
        $display("FAIL stl_byte%0d grant=%0d rdy=%b data=%h want 2/1/%h",
                 i, grant, stl_ready, tx_data, 8'(i));
      end
    end
    to_pos();
    asc_valid  = 1'b1;
    stat_valid = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, grant} !== 3'b000) begin
      failures++;
      $display("FAIL stl_release busy=%b grant=%0d want 0/0", busy, grant);
    end
    to_pos();
    @(negedge clk);
    checks++;
    if (grant !== 2'd3) begin
      failures++;
      $display("FAIL stl_last_rr grant=%0d want 3", grant);
    end
  endtask

  task automatic test_contention();
    int exp_g[$];
    logic [7:0] d [0:3];
    logic [2:0] rdy;
    d[0] = 8'h00; d[1] = 8'hA1; d[2] = 8'hB2; d[3] = 8'hC3;
    exp_g.push_back(0);
    for (int s = 1; s <= 3; s++) begin
      repeat (plen(s)) exp_g.push_back(s);
      exp_g.push_back(0);
    end
    exp_g.push_back(1);
    do_reset();
    {asc_valid, stl_valid, stat_valid} = 3'b111;
    asc_data = d[1]; stl_data = d[2]; stat_data = d[3];
    tx_ready = 1'b1;
    foreach (exp_g[k]) begin
      @(negedge clk);
      rdy = (exp_g[k] == 0) ? 3'b000 : 3'(1 << (exp_g[k] - 1));
      checks++;
      if ({grant, tx_data, stat_ready, stl_ready, asc_ready}
          !== {2'(exp_g[k]), d[exp_g[k]], rdy}) begin
        failures++;
        $display("FAIL contention_c%0d grant=%0d data=%h want %0d/%h",
                 k, grant, tx_data, exp_g[k], d[exp_g[k]]);
      end
      to_pos();
    end
    {asc_valid, stl_valid, stat_valid} = 3'b000;
  endtask

  task automatic test_backpressure();
    int nb = 0;
    do_reset();
    stl_valid = 1'b1;
    for (int k = 0; k < 32; k++) begin
      to_pos();
      tx_ready = 1'(k % 2);
      stl_data = 8'(nb);
      @(negedge clk);
      checks++;
      if ({grant, stl_ready, tx_data, timeout_pulse}
          !== {2'd2, tx_ready, 8'(nb), 1'b0}) begin
        failures++;
        $display("FAIL bp_c%0d grant=%0d rdy=%b data=%h to=%b want 2/%b/%h/0",
                 k, grant, stl_ready, tx_data, timeout_pulse, tx_ready,
                 8'(nb));
      end
      if (tx_ready) nb++;
    end
    to_pos();
    stl_valid = 1'b0;
    tx_ready  = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, grant, err_count} !== 11'd0 || nb != 16) begin
      failures++;
      $display("FAIL bp_done busy=%b grant=%0d err=%0d bytes=%0d",
               busy, grant, err_count, nb);
    end
  endtask

  task automatic test_stall();
    do_reset();
    stat_valid = 1'b1;
    tx_ready   = 1'b1;
    for (int k = 0; k < 2; k++) begin
      to_pos();
      stat_data = 8'h50 + 8'(k);
      @(negedge clk);
      checks++;
      if ({grant, stat_ready, tx_data} !== {2'd3, 1'b1, 8'h50 + 8'(k)}) begin
        failures++;
        $display("FAIL stall_byte%0d grant=%0d rdy=%b data=%h",
                 k, grant, stat_ready, tx_data);
      end
    end
    to_pos();
    stat_valid = 1'b0;
    asc_valid  = 1'b1;
    asc_data   = 8'h11;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) to_pos();
      @(negedge clk);
      checks++;
      if ({grant, busy, timeout_pulse, tx_valid, asc_ready}
          !== {2'd3, 4'b1000}) begin
        failures++;
        $display("FAIL stall_wait%0d grant=%0d busy=%b to=%b",
                 k, grant, busy, timeout_pulse);
      end
    end
    to_pos();
    @(negedge clk);
    checks++;
    if ({timeout_pulse, err_count, grant, busy} !== {1'b1, 8'd1, 3'b000}) begin
      failures++;
      $display("FAIL stall_abort to=%b err=%0d grant=%0d want 1/1/0",
               timeout_pulse, err_count, grant);
    end
    to_pos();
    @(negedge clk);
    checks++;
    if ({grant, timeout_pulse, asc_ready, tx_data}
        !== {2'd1, 2'b01, 8'h11}) begin
      failures++;
      $display("FAIL stall_next grant=%0d to=%b data=%h want 1/0/11",
               grant, timeout_pulse, tx_data);
    end
    to_pos();
    asc_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, err_count} !== {1'b0, 8'd1}) begin
      failures++;
      $display("FAIL stall_err_hold busy=%b err=%0d want 0/1",
               busy, err_count);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    stl_valid = 1'b1;
    tx_ready  = 1'b1;
    for (int i = 0; i <= 5; i++) begin
      to_pos();
      stl_data = 8'(i);
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({grant, busy, tx_valid, stl_ready, tx_data, err_count,
         timeout_pulse} !== 22'd0) begin
      failures++;
      $display("FAIL async_reset grant=%0d busy=%b txv=%b rdy=%b data=%h",
               grant, busy, tx_valid, stl_ready, tx_data);
    end
    to_pos();
    rst = 1'b0;
    stl_data = 8'h00;
    for (int i = 0; i < 16; i++) begin
      to_pos();
      stl_data = 8'(i);
      @(negedge clk);
      checks++;
      if ({grant, stl_ready, tx_data} !== {2'd2, 1'b1, 8'(i)}) begin
        failures++;
        $display("FAIL rerun_byte%0d grant=%0d data=%h want 2/%h",
                 i, grant, tx_data, 8'(i));
      end
    end
    to_pos();
    stl_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, grant, err_count} !== 11'd0) begin
      failures++;
      $display("FAIL rerun_done busy=%b grant=%0d err=%0d",
               busy, grant, err_count);
    end
  endtask

  task automatic test_random();
    logic [7:0] qa[$], qs[$], qt[$];
    int low [1:3];
    int m_last = 3, m_own = 0, m_cnt = 0, src, cyc = 0;
    logic [2:0] idle_req = 3'b000;
    logic [2:0] hsv;
    logic [7:0] want;
    for (int p = 0; p < 6; p++) qa.push_back(8'($urandom));
    for (int p = 0; p < 3 * STL_L; p++) qs.push_back(8'($urandom));
    for (int p = 0; p < 4 * STAT_L; p++) qt.push_back(8'($urandom));
    low[1] = 0; low[2] = 0; low[3] = 0;
    do_reset();
    while ((qa.size() + qs.size() + qt.size()) > 0 && cyc < 3000) begin
      cyc++;
      asc_valid  = qa.size() > 0 && (low[1] >= 3 || $urandom_range(2) != 0);
      stl_valid  = qs.size() > 0 && (low[2] >= 3 || $urandom_range(2) != 0);
      stat_valid = qt.size() > 0 && (low[3] >= 3 || $urandom_range(2) != 0);
      low[1] = asc_valid ? 0 : low[1] + 1;
      low[2] = stl_valid ? 0 : low[2] + 1;
      low[3] = stat_valid ? 0 : low[3] + 1;
      asc_data  = (qa.size() > 0) ? qa[0] : 8'h00;
      stl_data  = (qs.size() > 0) ? qs[0] : 8'h00;
      stat_data = (qt.size() > 0) ? qt[0] : 8'h00;
      tx_ready  = ($urandom_range(3) != 0);
      @(negedge clk);
      if (timeout_pulse) begin
        failures++;
        $display("FAIL rnd_timeout unexpected pulse at cycle %0d", cyc);
      end
      if (!busy) begin
        checks++;
        if (m_cnt != 0) begin
          failures++;
          $display("FAIL rnd_atomic idle after %0d of %0d bytes src %0d",
                   m_cnt, plen(m_own), m_own);
        end
        idle_req = {stat_valid, stl_valid, asc_valid};
      end
      hsv = {stat_ready && stat_valid, stl_ready && stl_valid,
             asc_ready && asc_valid};
      if (hsv != 3'b000) begin
        src  = hsv[0] ? 1 : hsv[1] ? 2 : 3;
        want = (src == 1) ? qa[0] : (src == 2) ? qs[0] : qt[0];
        if (m_cnt == 0) m_own = rr(m_last, idle_req);
        checks++;
        if ($countones(hsv) != 1 || src != m_own || grant !== 2'(m_own)
            || tx_data !== want) begin
          failures++;
          $display("FAIL rnd_hs cyc=%0d src=%0d grant=%0d data=%h want %0d/%h",
                   cyc, src, grant, tx_data, m_own, want);
        end
        if (src == 1) void'(qa.pop_front());
        else if (src == 2) void'(qs.pop_front());
        else void'(qt.pop_front());
        m_cnt++;
        if (m_cnt == plen(m_own)) begin
          m_last = m_own;
          m_cnt  = 0;
        end
      end
      to_pos();
    end
    {asc_valid, stl_valid, stat_valid} = 3'b000;
    @(negedge clk);
    checks++;
    if (cyc >= 3000 || err_count !== 8'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rnd_end cycles=%0d err=%0d busy=%b left=%0d",
               cyc, err_count, busy, qa.size() + qs.size() + qt.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_stl();
    test_contention();
    test_backpressure();
    test_stall();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
